window_gen_3x3: RTL
===================

# window_gen_3x3

Streaming 3x3 window generator that feeds the combinational 3x3 convolutor. It accepts a raster-order pixel stream over a valid/ready handshake and stores the two previous image lines in line buffers. For every interior pixel position it emits the complete 3x3 neighbourhood on ports u00..u22. No border padding: only fully populated windows are produced, so each frame yields (IMG_W-2)*(IMG_H-2) windows.

## Interface
Parameters:
- BITW, 8, pixel width (unsigned)
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  in_pixel valid
- in_pixel  in  BITW  raster-order pixel; x increments first, then y
- in_ready  out  1  block can accept a pixel this cycle
- out_valid  out  1  window on u00..u22 valid
- out_ready  in  1  downstream accepts the window
- u00,u01,u02  out  BITW each  top row (line y-2), columns x-2, x-1, x
- u10,u11,u12  out  BITW each  middle row (line y-1)
- u20,u21,u22  out  BITW each  bottom row (line y); u22 = newest pixel
- out_last  out  1  qualifies the final window of a frame (x=IMG_W-1, y=IMG_H-1)

## Operation
- Pixel accept: in_valid && in_ready. in_ready = out_ready || !out_valid (one output stage, combinational).
- Counters: x in 0..IMG_W-1, y in 0..IMG_H-1. Each accept advances x. At x=IMG_W-1, x wraps to 0 and y increments. At x=IMG_W-1 && y=IMG_H-1, both wrap to 0 (next frame).
- Line buffers: lb1[IMG_W] holds line y-1 and lb0[IMG_W] holds line y-2. On each accept at column x:
  - read mid=lb1[x] and top=lb0[x];
  - write lb0[x]<=lb1[x] and lb1[x]<=in_pixel.
- Window shift register, on accept only: column 0 <= column 1; column 1 <= column 2; column 2 <= {top, mid, in_pixel}. The window registers drive u00..u22 directly.
- Window qualification: an accepted pixel with x>=2 && y>=2 sets out_valid in the next cycle. out_last is set in the same cycle if that pixel is (IMG_W-1, IMG_H-1).
- Suppression: accepts with x<2 or y<2 do not raise out_valid. This hides both the line-buffer contents from the previous frame and the window columns carried over from the previous line end.
- out_valid clears after an out_ready handshake unless a new qualifying accept occurs in the same cycle, in which case it stays 1.
- Line buffers are not reset. Correctness relies only on the gating above.
- Pixel values are passed through unmodified; there is no arithmetic on pixel data.

## Timing
- Reset values: in_ready=1 (follows from out_valid=0), out_valid=0, out_last=0, u00..u22=0, x=0, y=0.
- Latency: 1 cycle from a qualifying accept to out_valid=1 with the matching window.
- Throughput: 1 pixel/cycle, giving 1 window/cycle in the interior region when out_ready=1.
- Backpressure: while out_valid && !out_ready, in_ready=0. u00..u22, out_valid and out_last hold stable, and the counters and line buffers do not change.
- in_valid may drop at any cycle. Bubbles cause no state change and are never output as windows.
- Simultaneous events: an output handshake and a new qualifying accept in the same cycle load the new window with out_valid staying 1. A handshake without a new qualifying accept drops out_valid to 0.
- Reset mid-frame:
  - the next edge forces the reset values and discards any pending window;
  - the first pixel accepted after reset is treated as (0,0) of a new frame;
  - no window is produced until y>=2 of that new frame.

## Test plan
- IMG_W=5, IMG_H=4, p(x,y)=10y+x, in_valid=1, out_ready=1:
  - exactly 6 windows, appearing 1 cycle after pixels (2,2), (3,2), (4,2), (2,3), (3,3), (4,3);
  - first window is u00..u22 = 0,1,2 / 10,11,12 / 20,21,22;
  - last window is 12,13,14 / 22,23,24 / 32,33,34 with out_last=1, and out_last=1 on no other window.
- Same image with out_ready=0 for 5 cycles at the first out_valid:
  - window stays 0..22 and in_ready=0 throughout;
  - after release, the window sequence is identical to the first scenario and no pixel is lost.
- Same image with in_valid pseudo-randomly deasserted about 50% of cycles: identical window sequence and count.
- Two back-to-back frames, the second with p+100:
  - the second frame's first window is 100,101,102 / 110,111,112 / 120,121,122;
  - no window mixes data from the two frames;
  - 12 windows total, out_last exactly twice.
- rst=1 for 1 cycle after 7 pixels accepted, then a full frame:
  - out_valid=0 and counters=0 on the cycle after reset;
  - the full frame then produces exactly the 6 windows of the first scenario.
- All pixels 255 (BITW=8), IMG_W=3, IMG_H=3: exactly one window, all nine outputs 255, out_last=1.

Source files
------------

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3-column shift window,
// emitting one window per accepted interior pixel over a single valid/ready output stage.
module window_gen_3x3 #(
    parameter int BITW  = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITW-1:0] in_pixel,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITW-1:0] u00,
    output logic [BITW-1:0] u01,
    output logic [BITW-1:0] u02,
    output logic [BITW-1:0] u10,
    output logic [BITW-1:0] u11,
    output logic [BITW-1:0] u12,
    output logic [BITW-1:0] u20,
    output logic [BITW-1:0] u21,
    output logic [BITW-1:0] u22,
    output logic            out_last
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [BITW-1:0] lb0 [IMG_W];
    logic [BITW-1:0] lb1 [IMG_W];
    logic [BITW-1:0] top;
    logic [BITW-1:0] mid;
    logic            accept;
    logic            qual;
    logic            at_end;

    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;
    assign top      = lb0[x];
    assign mid      = lb1[x];
    assign qual     = accept && (x >= X_TWO) && (y >= Y_TWO);
    assign at_end   = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Line buffers are never cleared; stale contents are hidden by the x/y qualification.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb0[x] <= lb1[x];
            lb1[x] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u00 <= '0; u01 <= '0; u02 <= '0;
            u10 <= '0; u11 <= '0; u12 <= '0;
            u20 <= '0; u21 <= '0; u22 <= '0;
        end else if (accept) begin
            u00 <= u01; u01 <= u02; u02 <= top;
            u10 <= u11; u11 <= u12; u12 <= mid;
            u20 <= u21; u21 <= u22; u22 <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (qual) begin
            out_valid <= 1'b1;
            out_last  <= at_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
